// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx with a three-state read sequencer.
// Define UART_FIFO_OVF_CNT_EN to add the saturating o_Ovf_Count dropped-byte counter.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic          o_TX_DV,
  output logic [7:0]    o_TX_Byte,
  input  logic          i_TX_Active,
  input  logic          i_TX_Done,
  output logic          o_Empty,
  output logic          o_Full,
  output logic [AW:0]   o_Count,
  output logic          o_Overflow,
  input  logic          i_Ovf_Clr
`ifdef UART_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]    o_Ovf_Count
`endif
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            ovf_event;

  assign o_Count = count;

  // Read sequencer and occupancy bookkeeping; a write to a full FIFO is dropped even if a pop frees a slot.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    push       = i_RX_DV && (count != FULL_CNT);
    ovf_event  = i_RX_DV && (count == FULL_CNT);
    case (state)
      IDLE: begin
        if ((count != '0) && !i_TX_Active) begin
          state_next = LOAD;
          pop        = 1'b1;
        end
      end
      LOAD:      state_next = WAIT_DONE;
      WAIT_DONE: if (i_TX_Done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= 8'h00;
      o_Empty   <= 1'b1;
      o_Full    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        o_TX_Byte <= mem[rd_ptr];
      end
      count   <= count_next;
      o_TX_DV <= (state_next == LOAD);
      o_Empty <= (count_next == '0);
      o_Full  <= (count_next == FULL_CNT);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_RX_Byte;
  end

  // Overflow set dominates a simultaneous clear.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Overflow <= 1'b0;
    end else if (ovf_event) begin
      o_Overflow <= 1'b1;
    end else if (i_Ovf_Clr) begin
      o_Overflow <= 1'b0;
    end
  end

`ifdef UART_FIFO_OVF_CNT_EN
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Ovf_Count <= 8'h00;
    end else if (ovf_event) begin
      if (i_Ovf_Clr)                 o_Ovf_Count <= 8'h01;
      else if (o_Ovf_Count != 8'hFF) o_Ovf_Count <= o_Ovf_Count + 8'h01;
    end else if (i_Ovf_Clr) begin
      o_Ovf_Count <= 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_byte_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done = 1'b0;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          ovf_clr = 1'b0;
`ifdef UART_FIFO_OVF_CNT_EN
  logic [7:0]    ovf_count;
`endif

  always #5 clk = ~clk;

  uart_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .o_TX_DV    (tx_dv),
    .o_TX_Byte  (tx_byte),
    .i_TX_Active(tx_active),
    .i_TX_Done  (tx_done),
    .o_Empty    (empty),
    .o_Full     (full),
    .o_Count    (count),
    .o_Overflow (ovf),
    .i_Ovf_Clr  (ovf_clr)
`ifdef UART_FIFO_OVF_CNT_EN
    ,
    .o_Ovf_Count(ovf_count)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // uart_tx stand-in: busy from o_TX_DV until a Done strobe 10 cycles later.
  logic          tx_hold = 1'b0;
  logic          tx_busy = 1'b0;
  int            tx_cnt  = 0;
  byte unsigned  out_q[$];
  assign tx_active = tx_hold | tx_busy;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_busy = 1'b0;
      tx_cnt  = 0;
    end else if (tx_dv) begin
      out_q.push_back(tx_byte);
      tx_busy = 1'b1;
      tx_cnt  = 10;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_busy = 1'b0;
      end
    end
  end

  // Reference model: a byte queue plus a reader that is free, strobing, or waiting for Done.
  byte unsigned  mq[$];
  int            m_phase = 0;
  logic          m_dv = 1'b0;
  logic [7:0]    m_byte = 8'h00;
  logic          m_ovf = 1'b0;
  int            m_ocnt = 0;
  bit            m_full;
  bit            m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_dv    = 1'b0;
      m_byte  = 8'h00;
      m_ovf   = 1'b0;
      m_ocnt  = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (m_phase == 0) && (mq.size() > 0) && !tx_active;
      m_dv   = m_pop;
      if (m_pop) m_byte = mq.pop_front();
      if (rx_dv && !m_full) mq.push_back(rx_byte);
      if (rx_dv && m_full) begin
        m_ovf  = 1'b1;
        m_ocnt = ovf_clr ? 1 : ((m_ocnt == 255) ? 255 : m_ocnt + 1);
      end else if (ovf_clr) begin
        m_ovf  = 1'b0;
        m_ocnt = 0;
      end
      if (m_pop)                        m_phase = 1;
      else if (m_phase == 1)            m_phase = 2;
      else if (m_phase == 2 && tx_done) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count",   32'(count),   32'(mq.size()));
      chk("empty",   32'(empty),   32'(mq.size() == 0));
      chk("full",    32'(full),    32'(mq.size() == DEPTH));
      chk("ovf",     32'(ovf),     32'(m_ovf));
      chk("tx_dv",   32'(tx_dv),   32'(m_dv));
      chk("tx_byte", 32'(tx_byte), 32'(m_byte));
`ifdef UART_FIFO_OVF_CNT_EN
      chk("ovf_count", 32'(ovf_count), 32'(m_ocnt));
`endif
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mq.size() != 0 || m_phase != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic clear_ovf();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"},   32'(empty),   32'd1);
    chk({tag, "_full"},    32'(full),    32'd0);
    chk({tag, "_count"},   32'(count),   32'd0);
    chk({tag, "_tx_dv"},   32'(tx_dv),   32'd0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 32'h00);
    chk({tag, "_ovf"},     32'(ovf),     32'd0);
  endtask

  byte unsigned sent[$];

  initial begin
    byte unsigned b;
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Single byte latency
    out_q.delete();
    @(negedge clk); rx_dv = 1'b1; rx_byte = 8'hA5;
    @(negedge clk); rx_dv = 1'b0;
    chk("t1_count_after_push", 32'(count), 32'd1);
    chk("t1_no_dv_yet",        32'(tx_dv), 32'd0);
    @(negedge clk);
    chk("t1_dv",         32'(tx_dv),   32'd1);
    chk("t1_byte",       32'(tx_byte), 32'hA5);
    chk("t1_count_zero", 32'(count),   32'd0);
    @(negedge clk);
    chk("t1_dv_one_cycle", 32'(tx_dv), 32'd0);
    wait_idle(100);

    // Burst of five
    out_q.delete();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_byte = 8'(i);
    end
    @(negedge clk); rx_dv = 1'b0;
    wait_idle(300);
    chk("t2_n", 32'(out_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < out_q.size(); i++) chk("t2_order", 32'(out_q[i]), 32'(i + 1));

    // Fill to full with uart_tx held busy, then overflow
    tx_hold = 1'b1;
    out_q.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("t3_full_after16", 32'(full), 32'd1);
        chk("t3_no_ovf_yet",   32'(ovf),  32'd0);
      end
      rx_dv = 1'b1; rx_byte = 8'(8'h10 + i);
    end
    @(negedge clk); rx_dv = 1'b0;
    chk("t3_full",  32'(full),  32'd1);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf",   32'(ovf),   32'd1);
`ifdef UART_FIFO_OVF_CNT_EN
    chk("t3_ovf_count", 32'(ovf_count), 32'd1);
`endif
    clear_ovf();
    chk("t3_ovf_cleared", 32'(ovf), 32'd0);
`ifdef UART_FIFO_OVF_CNT_EN
    chk("t3_ovf_count_cleared", 32'(ovf_count), 32'd0);
`endif
    // Clear and overflow on the same edge: overflow wins
    @(negedge clk); ovf_clr = 1'b1; rx_dv = 1'b1; rx_byte = 8'hEE;
    @(negedge clk); ovf_clr = 1'b0; rx_dv = 1'b0;
    chk("t3_clr_vs_ovf", 32'(ovf), 32'd1);
`ifdef UART_FIFO_OVF_CNT_EN
    chk("t3_clr_vs_ovf_count", 32'(ovf_count), 32'd1);
`endif
    clear_ovf();
    // Write while full on the same edge as a pop: still dropped
    @(negedge clk); tx_hold = 1'b0; rx_dv = 1'b1; rx_byte = 8'hDD;
    @(negedge clk); rx_dv = 1'b0;
    chk("t3_pop_drop_count", 32'(count), 32'd15);
    chk("t3_pop_drop_ovf",   32'(ovf),   32'd1);
    wait_idle(400);
    chk("t3_n", 32'(out_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_q.size(); i++) chk("t3_order", 32'(out_q[i]), 32'(8'h10 + i));
    clear_ovf();

    // Wrap-around with random gaps
    out_q.delete();
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(6, 14)) @(negedge clk);
      rx_dv = 1'b1; rx_byte = b; sent.push_back(b);
      @(negedge clk); rx_dv = 1'b0;
    end
    wait_idle(1000);
    chk("t4_n", 32'(out_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < out_q.size(); i++) chk("t4_order", 32'(out_q[i]), 32'(sent[i]));
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_ovf",   32'(ovf),   32'd0);

    // Reset while a byte is in flight and three are queued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_byte = 8'(8'hC1 + i);
    end
    @(negedge clk); rx_dv = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_queued", 32'(count), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("t5_rst");
    rst_n = 1'b1;
    out_q.delete();
    repeat (30) @(negedge clk);
    chk("t5_no_dv", 32'(out_q.size()), 32'd0);
    @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h5A;
    @(negedge clk); rx_dv = 1'b0;
    wait_idle(100);
    chk("t5_new_n",    32'(out_q.size()), 32'd1);
    if (out_q.size() > 0) chk("t5_new_byte", 32'(out_q[0]), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
